// File: rtl/bram_frame_writer_pkg.sv
// Shared definitions for the 1-bit frame buffer writer and display reader:
// geometry defaults, FSM encoding, pixel field layout and address packing.
package bram_frame_writer_pkg;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    // 30-bit pixel is {R,G,B}, 10 bits per channel
    localparam int CW    = 10;
    localparam int R_LSB = 20;
    localparam int G_LSB = 10;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CLEAR   = 2'd3
    } state_e;

    function automatic logic [18:0] pack_addr(input logic [8:0] y, input logic [9:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/bram_frame_writer_pixel_binarizer.sv
// Combinational pixel binarizer: luma = (R + 2G + B) >> 2, compared with a threshold.
module pixel_binarizer
    import bram_frame_writer_pkg::*;
(
    input  logic [29:0] pix_i,
    input  logic [11:0] thr_i,
    output logic        bit_o
);

    logic [11:0] sum;
    logic [11:0] luma;

    // Max sum is 1023 + 2046 + 1023 = 4092, so 12 bits never overflow
    assign sum  = 12'(pix_i[R_LSB +: CW]) + {1'b0, pix_i[G_LSB +: CW], 1'b0} + 12'(pix_i[B_LSB +: CW]);
    assign luma = sum >> 2;
    assign bit_o = (luma >= thr_i);

endmodule

// File: rtl/bram_frame_writer.sv
// Binarising raster writer into a 1-bit frame buffer with single-frame capture
// and whole-buffer clear; all BRAM write outputs are registered.
module bram_frame_writer
    import bram_frame_writer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic [11:0] threshold,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_eol,
    input  logic [29:0] pix_data,
    output logic        busy,
    output logic        frame_done,
    output logic        line_error,
    output logic        bram_we,
    output logic [18:0] bram_addr,
    output logic        bram_write_data
);

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    state_e      state_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        we_q;
    logic [18:0] addr_q;
    logic        wdata_q;
    logic        done_pend_q;
    logic        frame_done_q;
    logic        line_error_q;

    logic        pix_bit;
    logic [9:0]  cur_x;
    logic [8:0]  cur_y;

    pixel_binarizer u_bin (
        .pix_i (pix_data),
        .thr_i (threshold),
        .bit_o (pix_bit)
    );

    // A start-of-frame pixel always lands at (0,0), whether arming or restarting
    assign cur_x = pix_sof ? 10'd0 : x_q;
    assign cur_y = pix_sof ? 9'd0  : y_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            line_error_q <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            wdata_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= done_pend_q;
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q <= ST_CLEAR;
                        x_q     <= '0;
                        y_q     <= '0;
                    end else if (start) begin
                        state_q      <= ST_ARM;
                        x_q          <= '0;
                        y_q          <= '0;
                        line_error_q <= 1'b0;
                    end
                end
                ST_ARM, ST_CAPTURE: begin
                    if (pix_valid && (pix_sof || state_q == ST_CAPTURE)) begin
                        state_q <= ST_CAPTURE;
                        if (state_q == ST_CAPTURE && pix_sof) line_error_q <= 1'b1;
                        if (pix_eol) begin
                            we_q    <= 1'b1;
                            addr_q  <= pack_addr(cur_y, cur_x);
                            wdata_q <= pix_bit;
                            x_q     <= '0;
                            if (cur_x != X_LAST) line_error_q <= 1'b1;
                            if (cur_y == Y_LAST) begin
                                state_q     <= ST_IDLE;
                                done_pend_q <= 1'b1;
                            end else begin
                                y_q <= cur_y + 9'd1;
                            end
                        end else if (cur_x == X_LAST) begin
                            // overlong line: hold at the last column and drop pixels until eol
                            x_q          <= cur_x;
                            y_q          <= cur_y;
                            line_error_q <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= pack_addr(cur_y, cur_x);
                            wdata_q <= pix_bit;
                            x_q     <= cur_x + 10'd1;
                            y_q     <= cur_y;
                        end
                    end
                end
                ST_CLEAR: begin
                    we_q    <= 1'b1;
                    addr_q  <= pack_addr(y_q, x_q);
                    wdata_q <= 1'b0;
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        if (y_q == Y_LAST) begin
                            state_q     <= ST_IDLE;
                            done_pend_q <= 1'b1;
                        end else begin
                            y_q <= y_q + 9'd1;
                        end
                    end else begin
                        x_q <= x_q + 10'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = frame_done_q;
    assign line_error      = line_error_q;
    assign bram_we         = we_q;
    assign bram_addr       = addr_q;
    assign bram_write_data = wdata_q;

endmodule

// File: tb/tb_bram_frame_writer.sv
// Scoreboard bench for bram_frame_writer on a reduced 16x8 frame.
module tb_bram_frame_writer;

    localparam int W = 16;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] threshold = 12'd512;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic [29:0] pix_data = '0;
    logic        busy, frame_done, line_error, bram_we, bram_write_data;
    logic [18:0] bram_addr;

    bram_frame_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .clear           (clear),
        .threshold       (threshold),
        .pix_valid       (pix_valid),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_data        (pix_data),
        .busy            (busy),
        .frame_done      (frame_done),
        .line_error      (line_error),
        .bram_we         (bram_we),
        .bram_addr       (bram_addr),
        .bram_write_data (bram_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] a;
        logic        d;
    } wr_t;

    wr_t q[$];
    int total = 0, bad = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, last_we_cyc = 0, run = 0, last_run = 0;
    logic [18:0] last_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rbit(input logic [29:0] d);
        int s;
        s = int'(d[29:20]) + 2 * int'(d[19:10]) + int'(d[9:0]);
        return (s / 4) >= int'(threshold);
    endfunction

    function automatic logic [18:0] ad(input int x, input int y);
        return 19'(y * 1024 + x);
    endfunction

    always @(posedge clk) begin
        wr_t e;
        #1;
        cyc++;
        if (reset) begin
            run = 0;
        end else begin
            if (bram_we) begin
                wr_cnt++;
                last_we_cyc = cyc;
                last_addr = bram_addr;
                run++;
                if (q.size() == 0) begin
                    chk("unexpected_we", 32'(bram_we), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("addr", 32'(bram_addr), 32'(e.a));
                    chk("data", 32'(bram_write_data), 32'(e.d));
                end
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_gap", 32'(cyc - last_we_cyc), 32'd1);
            end
        end
    end

    task automatic px(input logic [29:0] d, input bit sof, input bit eol, input bit ex,
                      input int x, input int y);
        if (ex) begin
            wr_t e;
            e.a = ad(x, y);
            e.d = rbit(d);
            q.push_back(e);
        end
        @(negedge clk);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_eol   = eol;
        pix_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            pix_eol   = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_lines(input int ys, input int ye, input int xs, input bit sof1);
        for (int y = ys; y <= ye; y++) begin
            for (int x = (y == ys) ? xs : 0; x < W; x++) begin
                if ($urandom_range(7) == 0) idle(1);
                px(30'($urandom), sof1 && y == ys && x == xs, x == W - 1, 1'b1, x, y);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic push_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                wr_t e;
                e.a = ad(x, y);
                e.d = 1'b0;
                q.push_back(e);
            end
    endtask

    initial begin
        int d0, w0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(line_error), 32'd0);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_wdata", 32'(bram_write_data), 32'd0);
        reset = 1'b0;

        // clear, with start asserted alongside (clear must win) and again mid-run
        push_clear();
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        wait_done(W * H + 20);
        chk("clr_run", 32'(last_run), 32'(W * H));
        chk("clr_last", 32'(last_addr), 32'(ad(W - 1, H - 1)));
        chk("clr_q", 32'(q.size()), 32'd0);
        idle(2);
        chk("clr_idle", 32'(busy), 32'd0);

        // full capture; junk before sof is ignored, threshold edge pixels up front
        threshold = 12'd512;
        pulse_start();
        chk("arm_busy", 32'(busy), 32'd1);
        px(30'h3FFFFFFF, 1'b0, 1'b0, 1'b0, 0, 0);
        px(30'h3FFFFFFF, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(2);
        px(30'h3FFFFFFF, 1'b1, 1'b0, 1'b1, 0, 0);
        px({10'd512, 10'd512, 10'd512}, 1'b0, 1'b0, 1'b1, 1, 0);
        px({10'd511, 10'd512, 10'd512}, 1'b0, 1'b0, 1'b1, 2, 0);
        run_lines(0, H - 1, 3, 1'b0);
        idle(1);
        wait_done(50);
        chk("cap_last", 32'(last_addr), 32'(ad(W - 1, H - 1)));
        chk("cap_err", 32'(line_error), 32'd0);
        chk("cap_q", 32'(q.size()), 32'd0);
        idle(2);
        chk("cap_idle", 32'(busy), 32'd0);

        // short line 3 (eol at x=5)
        threshold = 12'd300;
        pulse_start();
        run_lines(0, 2, 0, 1'b1);
        for (int x = 0; x <= 5; x++) px(30'($urandom), 1'b0, x == 5, 1'b1, x, 3);
        idle(1);
        chk("short_err", 32'(line_error), 32'd1);
        run_lines(4, H - 1, 0, 1'b0);
        idle(1);
        wait_done(50);
        chk("short_err_held", 32'(line_error), 32'd1);
        chk("short_q", 32'(q.size()), 32'd0);

        // long line 0: W+6 pixels, eol on the last; tail pixels share one value
        idle(2);
        pulse_start();
        chk("start_clr_err", 32'(line_error), 32'd0);
        for (int i = 0; i < W + 6; i++) begin
            if (i < W - 1)
                px(30'($urandom), i == 0, 1'b0, 1'b1, i, 0);
            else
                px(30'h3FFFFFFF, 1'b0, i == W + 5, i == W + 5, W - 1, 0);
        end
        run_lines(1, H - 1, 0, 1'b0);
        idle(1);
        wait_done(50);
        chk("long_err", 32'(line_error), 32'd1);
        chk("long_q", 32'(q.size()), 32'd0);

        // sof mid-frame at (5,2) restarts the frame
        idle(2);
        d0 = done_cnt;
        pulse_start();
        run_lines(0, 1, 0, 1'b1);
        for (int x = 0; x < 5; x++) px(30'($urandom), 1'b0, 1'b0, 1'b1, x, 2);
        px(30'($urandom), 1'b1, 1'b0, 1'b1, 0, 0);
        run_lines(0, H - 1, 1, 1'b0);
        idle(1);
        wait_done(50);
        chk("sof_err", 32'(line_error), 32'd1);
        chk("sof_q", 32'(q.size()), 32'd0);
        idle(5);
        chk("sof_one_done", 32'(done_cnt - d0), 32'd1);

        // reset on the 50th write of a clear
        push_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 200 && (wr_cnt - w0) < 50; i++) @(negedge clk);
        chk("rst_reach", 32'(wr_cnt - w0), 32'd50);
        reset = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #2;
        chk("midrst_we", 32'(bram_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        repeat (W * H) @(negedge clk);
        chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_frame_writer.md
Name: bram_frame_writer

Overview:
Write-side counterpart to the 1-bit frame-buffer display reader. Accepts a raster pixel stream of 30-bit {R,G,B} pixels, binarises each pixel against a luminance threshold, and writes one bit per pixel into the 640x480 single-bit BRAM. The write address is {y[8:0], x[9:0]}, the same mapping the display reader uses. Also provides a clear mode that zeroes the whole frame buffer, and single-frame capture control for the host FSM.

Parameters:
WIDTH, 640, active pixels per line; must be ≤1024.
HEIGHT, 480, active lines per frame; must be ≤512.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; arm capture of the next complete frame
clear  in  1  pulse; zero entire buffer
threshold  in  12  luminance threshold, compared with the 12-bit luma sum
pix_valid  in  1  pixel qualifier
pix_sof  in  1  marks first pixel of a frame; valid only with pix_valid
pix_eol  in  1  marks last pixel of a line; valid only with pix_valid
pix_data  in  30  {R[29:20],G[19:10],B[9:0]}
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when a capture or clear completes
line_error  out  1  sticky flag for a malformed line or frame; cleared by reset or start
bram_we  out  1  write strobe
bram_addr  out  19  {y[8:0], x[9:0]}
bram_write_data  out  1  pixel bit

Behaviour:
- Reset values: all outputs 0, state IDLE, x=0, y=0.
- Luma: sum = R + 2G + B, 12 bits, computed without overflow. Output bit = (sum[11:2] zero-extended to 12 bits ≥ threshold).
- Latency: a pixel accepted in cycle n produces bram_we=1, with its addr and data, in cycle n+1. All three outputs are registered.
- The block applies no backpressure. Every pix_valid pixel in CAPTURE is consumed.
- States:
  - IDLE:
    - clear=1 → CLEAR. clear wins over start when both are asserted in the same cycle.
    - start=1 → ARM, and line_error is cleared.
  - ARM:
    - Pixels are ignored until pix_valid & pix_sof.
    - That pixel is written at (0,0), and the state moves to CAPTURE.
  - CAPTURE, per valid pixel:
    - Write at (x,y).
    - eol with x==WIDTH-1: x←0, y←y+1.
    - eol with x<WIDTH-1 (short line): x←0, y←y+1, line_error←1.
    - x==WIDTH-1 without eol (long line): x is held, the write is suppressed, line_error←1, and pixels are discarded until eol.
    - eol on line HEIGHT-1: frame_done pulses in the cycle after the final write, then → IDLE.
    - sof while in CAPTURE: the frame restarts, that pixel is written at (0,0), and line_error←1.
  - CLEAR:
    - Writes data 0 at every (x,y), x in 0..WIDTH-1 and y in 0..HEIGHT-1, one write per cycle, raster order.
    - Total WIDTH*HEIGHT cycles, i.e. 307200 at the defaults.
    - frame_done pulses after the last write, then → IDLE.
- start and clear are ignored outside IDLE.
- Addresses with x ≥ WIDTH are never written.
- Reset mid-operation: bram_we drops in the next cycle, then IDLE with no frame_done.

Decomposition:
- Shared package holds:
  - address packing function {y[8:0], x[9:0]};
  - WIDTH/HEIGHT defaults;
  - state encoding for IDLE, ARM, CAPTURE, CLEAR;
  - pixel field offsets R/G/B, shared with the display reader.
- One sub-module: pixel_binarizer. It is combinational: luma plus threshold compare.
- The FSM and x/y counters stay in the top-level block.

Test Plan:
- Clear: pulse clear → busy=1, then 307200 consecutive writes with data 0, the last at addr {9'd479,10'd639}, then a single frame_done pulse and busy=0.
- Full capture: threshold=12'd512, start, then one 640x480 frame with pixel (0,0)=30'h3FFFFFFF and all others 0 → the first write is addr 0 data 1, all others data 0, frame_done appears 1 cycle after the write at addr {479,639}, and line_error=0.
- Short line: line 3 ends with eol at x=100 → the next pixel writes addr {9'd4,10'd0}, line_error=1 and stays set until the next start.
- Long line: line 0 has 700 pixels with eol on the 700th → exactly 640 writes for that line, and line_error=1.
- SOF mid-frame: pix_sof occurs at (200,10) → that pixel writes addr 0, the capture then completes a full frame, and line_error=1.
- Reset on the 1000th write of a clear → bram_we=0 in the next cycle, busy=0, and no frame_done; start and clear pulsed while busy produce no effect.
